// File: rtl/ble_ring_reader.sv
// Drains the BLE receive ring from RAM over Wishbone and forwards each low byte
// to uart_tx with a start/done handshake, chasing the writer's pointer.
module ble_ring_reader #(
   parameter int unsigned    AW     = 32,
   parameter logic [AW-1:0]  ADR_LL = AW'('h730),
   parameter logic [AW-1:0]  ADR_UL = AW'('h1FFC)
) (
   input  logic           i_wb_clk,
   input  logic           i_wb_rst,
   input  logic           i_en,
   input  logic [AW-1:0]  i_wr_ptr,
   input  logic           i_wb_gnt,
   output logic [AW-1:0]  o_wb_adr,
   output logic           o_wb_cyc,
   input  logic [31:0]    i_wb_rdt,
   input  logic           i_wb_ack,
   output logic [7:0]     o_tx_dat,
   output logic           o_tx_active,
   input  logic           i_tx_done,
   output logic [AW-1:0]  o_rd_ptr,
   output logic           o_empty,
   output logic [15:0]    o_sent
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SEND,
      ST_WAIT,
      ST_ADV
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic           cyc_q, cyc_d;
   logic [7:0]     tx_dat_q, tx_dat_d;
   logic [15:0]    sent_q, sent_d;

   logic [AW-1:0]  wr_norm;
   logic [AW:0]    rd_inc;
   logic [AW-1:0]  rd_next;
   logic           empty;
   logic           unused_rdt_hi;

   // Out-of-range writer values (including its transient UL+4) read as ADR_LL.
   always_comb begin
      wr_norm = i_wr_ptr;
      if ((i_wr_ptr > ADR_UL) || (i_wr_ptr < ADR_LL)) begin
         wr_norm = ADR_LL;
      end
   end

   assign empty = (rd_ptr_q == wr_norm);

   // One extra bit keeps the +4 from wrapping silently near the top of the address space.
   always_comb begin
      rd_inc  = {1'b0, rd_ptr_q} + (AW+1)'(4);
      rd_next = rd_inc[AW-1:0];
      if (rd_inc > {1'b0, ADR_UL}) begin
         rd_next = ADR_LL;
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      adr_d    = adr_q;
      cyc_d    = cyc_q;
      tx_dat_d = tx_dat_q;
      sent_d   = sent_q;
      case (state_q)
         ST_IDLE: begin
            if (i_en && !empty && i_wb_gnt) begin
               cyc_d   = 1'b1;
               adr_d   = rd_ptr_q;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (i_wb_ack) begin
               tx_dat_d = i_wb_rdt[7:0];
               cyc_d    = 1'b0;
               state_d  = ST_SEND;
            end else if (!i_wb_gnt) begin
               cyc_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_tx_done) begin
               state_d = ST_ADV;
            end
         end
         ST_ADV: begin
            rd_ptr_d = rd_next;
            sent_d   = sent_q + 16'd1;
            state_d  = ST_IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= ADR_LL;
         adr_q    <= ADR_LL;
         cyc_q    <= 1'b0;
         tx_dat_q <= '0;
         sent_q   <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         adr_q    <= adr_d;
         cyc_q    <= cyc_d;
         tx_dat_q <= tx_dat_d;
         sent_q   <= sent_d;
      end
   end

   assign unused_rdt_hi = ^i_wb_rdt[31:8];

   assign o_wb_adr    = adr_q;
   assign o_wb_cyc    = cyc_q;
   assign o_tx_dat    = tx_dat_q;
   assign o_tx_active = (state_q == ST_SEND);
   assign o_rd_ptr    = rd_ptr_q;
   assign o_empty     = empty;
   assign o_sent      = sent_q;

endmodule

// File: tb/tb_ble_ring_reader.sv
// Randomized bench for ble_ring_reader: byte-array RAM, ring writer, uart stand-in
// and an in-order byte/pointer reference model.
module tb_ble_ring_reader;

   localparam logic [31:0] LL = 32'h730;
   localparam logic [31:0] UL = 32'h1FFC;
   localparam int          N  = int'((UL - LL) / 4) + 1;

   logic        clk = 1'b0;
   logic        i_wb_rst = 1'b1;
   logic        i_en = 1'b0;
   logic [31:0] i_wr_ptr = LL;
   logic        i_wb_gnt = 1'b1;
   logic [31:0] o_wb_adr;
   logic        o_wb_cyc;
   logic [31:0] ram_rdt = '0;
   logic        ram_ack = 1'b0;
   logic [7:0]  o_tx_dat;
   logic        o_tx_active;
   logic        i_tx_done = 1'b0;
   logic [31:0] o_rd_ptr;
   logic        o_empty;
   logic [15:0] o_sent;

   ble_ring_reader #(.AW(32), .ADR_LL(LL), .ADR_UL(UL)) dut (
      .i_wb_clk    (clk),
      .i_wb_rst    (i_wb_rst),
      .i_en        (i_en),
      .i_wr_ptr    (i_wr_ptr),
      .i_wb_gnt    (i_wb_gnt),
      .o_wb_adr    (o_wb_adr),
      .o_wb_cyc    (o_wb_cyc),
      .i_wb_rdt    (ram_rdt),
      .i_wb_ack    (ram_ack),
      .o_tx_dat    (o_tx_dat),
      .o_tx_active (o_tx_active),
      .i_tx_done   (i_tx_done),
      .o_rd_ptr    (o_rd_ptr),
      .o_empty     (o_empty),
      .o_sent      (o_sent)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [N];
   logic       ram_ack_en = 1'b1;
   logic       gnt_at_edge = 1'b0;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (a < LL || a > UL) return 8'h00;
      return mem[int'((a - LL) >> 2)];
   endfunction

   // servant_ram-like slave seen through the arbiter: acks one cycle after a granted cyc
   always @(posedge clk) begin
      ram_ack     <= ram_ack_en && o_wb_cyc && i_wb_gnt && !ram_ack;
      ram_rdt     <= {o_wb_adr[23:0] ^ 24'hA5C35A, mem_rd(o_wb_adr)};
      gnt_at_edge <= i_wb_gnt;
   end

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model: next address to be read and bytes fully sent
   logic [31:0] model_rd = LL;
   int          model_sent = 0;

   function automatic logic [31:0] ring_next(input logic [31:0] a);
      return (a == UL) ? LL : a + 32'd4;
   endfunction

   int  cyc_n = 0, cyc_rise_at = 0, done_cyc = 0;
   bit  have_done = 0;
   int  cyc_rises = 0, tx_cnt = 0;
   bit  cyc_prev = 0, tx_prev = 0;
   bit  uart_busy = 0, uart_hold = 0, stray_done = 0;
   int  uart_cnt = 0;

   task automatic step();
      @(negedge clk);
      cyc_n++;
      if (o_wb_cyc && !cyc_prev) begin
         cyc_rises++;
         check_eq("cyc_needs_gnt", 32'(gnt_at_edge), 32'd1);
         check_eq("cyc_adr", o_wb_adr, model_rd);
         if (have_done) check_eq("done_to_cyc_gap", 32'(cyc_n - done_cyc >= 3), 32'd1);
         cyc_rise_at = cyc_n;
      end
      i_tx_done = 1'b0;
      if (stray_done) begin
         i_tx_done  = 1'b1;
         stray_done = 0;
      end else if (uart_busy && !uart_hold) begin
         if (uart_cnt == 0) begin
            i_tx_done  = 1'b1;
            uart_busy  = 0;
            model_rd   = ring_next(model_rd);
            model_sent++;
            done_cyc   = cyc_n;
            have_done  = 1;
         end else begin
            uart_cnt--;
         end
      end
      if (o_tx_active) begin
         check_eq("tx_single_cycle", 32'(tx_prev), 32'd0);
         check_eq("cyc_to_tx_latency", 32'(cyc_n - cyc_rise_at), 32'd2);
         check_eq("tx_dat", 32'(o_tx_dat), 32'(mem_rd(model_rd)));
         tx_cnt++;
         uart_busy = 1;
         uart_cnt  = int'($urandom_range(0, 3));
      end
      cyc_prev = o_wb_cyc;
      tx_prev  = o_tx_active;
   endtask

   task automatic wait_tx(input int budget);
      int start = tx_cnt;
      for (int i = 0; i < budget; i++) begin
         step();
         if (tx_cnt != start) return;
      end
      check_eq("wait_tx_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (o_empty && !uart_busy && !o_wb_cyc && o_rd_ptr == model_rd) return;
      end
      check_eq("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_rd_ptr"}, o_rd_ptr, model_rd);
      check_eq({tag, "_sent"}, 32'(o_sent), 32'(model_sent[15:0]));
   endtask

   initial begin
      int base_tx, base_rise, wr_idx, guard;
      for (int i = 0; i < N; i++) mem[i] = 8'h00;

      // reset
      repeat (3) step();
      i_wb_rst = 1'b0;
      check_eq("rst_rd_ptr", o_rd_ptr, LL);
      check_eq("rst_adr", o_wb_adr, LL);
      check_eq("rst_cyc", 32'(o_wb_cyc), 32'd0);
      check_eq("rst_tx_active", 32'(o_tx_active), 32'd0);
      check_eq("rst_tx_dat", 32'(o_tx_dat), 32'd0);
      check_eq("rst_sent", 32'(o_sent), 32'd0);

      // writer at ADR_LL: nothing to read
      i_en = 1'b1;
      base_rise = cyc_rises;
      repeat (100) step();
      check_eq("empty_flag", 32'(o_empty), 32'd1);
      check_eq("empty_no_cyc", 32'(cyc_rises - base_rise), 32'd0);
      check_eq("empty_rd_ptr", o_rd_ptr, LL);

      // two bytes
      mem[0] = 8'h41; mem[1] = 8'h42;
      base_tx = tx_cnt;
      i_wr_ptr = 32'h738;
      drain(200);
      check_eq("two_tx_count", 32'(tx_cnt - base_tx), 32'd2);
      check_eq("two_sent", 32'(o_sent), 32'd2);
      check_eq("two_rd_ptr", o_rd_ptr, 32'h738);
      check_eq("two_empty", 32'(o_empty), 32'd1);

      // grant loss before ack, then retry
      mem[2] = 8'h77;
      ram_ack_en = 1'b0;
      base_tx = tx_cnt;
      i_wr_ptr = 32'h73C;
      guard = 0;
      while (!o_wb_cyc && guard < 50) begin step(); guard++; end
      check_eq("gl_cyc_seen", 32'(o_wb_cyc), 32'd1);
      i_wb_gnt = 1'b0;
      repeat (5) step();
      check_eq("gl_cyc_dropped", 32'(o_wb_cyc), 32'd0);
      check_eq("gl_no_tx", 32'(tx_cnt - base_tx), 32'd0);
      check_eq("gl_rd_ptr", o_rd_ptr, 32'h738);
      ram_ack_en = 1'b1;
      i_wb_gnt = 1'b1;
      drain(200);
      check_eq("gl_tx_once", 32'(tx_cnt - base_tx), 32'd1);
      check_state("gl");

      // i_en drop while waiting for done, 3 bytes pending
      for (int i = 3; i < 6; i++) mem[i] = 8'($urandom);
      uart_hold = 1;
      i_wr_ptr = 32'h748;
      wait_tx(50);
      i_en = 1'b0;
      repeat (3) step();
      uart_hold = 0;
      base_rise = cyc_rises;
      repeat (60) step();
      check_eq("en_no_cyc", 32'(cyc_rises - base_rise), 32'd0);
      check_eq("en_sent", 32'(o_sent), 32'd4);
      check_eq("en_not_empty", 32'(o_empty), 32'd0);
      check_state("en");
      i_en = 1'b1;
      drain(300);
      check_state("en_resume");

      // reset in WAIT
      mem[6] = 8'h3C;
      uart_hold = 1;
      i_wr_ptr = 32'h74C;
      wait_tx(50);
      repeat (2) step();
      i_wb_rst = 1'b1;
      i_wr_ptr = LL;
      step();
      i_wb_rst = 1'b0;
      check_eq("wrst_cyc", 32'(o_wb_cyc), 32'd0);
      check_eq("wrst_adr", o_wb_adr, LL);
      check_eq("wrst_tx_active", 32'(o_tx_active), 32'd0);
      check_eq("wrst_tx_dat", 32'(o_tx_dat), 32'd0);
      model_rd = LL; model_sent = 0;
      uart_busy = 0; uart_hold = 0; have_done = 0;
      check_state("wrst");
      base_rise = cyc_rises;
      stray_done = 1;
      repeat (10) step();
      check_state("wrst_stray_done");
      check_eq("wrst_no_cyc", 32'(cyc_rises - base_rise), 32'd0);

      // random run around the ring up to the last slot, with grant flicker
      wr_idx = 0;
      guard = 0;
      while (wr_idx < N - 1 && guard < 60000) begin
         if (($urandom % 2) == 0 && (wr_idx - int'((model_rd - LL) >> 2)) < 16) begin
            mem[wr_idx] = 8'($urandom);
            wr_idx++;
            i_wr_ptr = LL + 32'(4 * wr_idx);
         end
         i_wb_gnt = (($urandom % 4) != 0);
         step();
         guard++;
      end
      i_wb_gnt = 1'b1;
      drain(500);
      check_eq("rand_rd_at_ul", o_rd_ptr, UL);
      check_state("rand");

      // wrap: writer shows its transient UL+4
      mem[N-1] = 8'h5A;
      i_wr_ptr = UL + 32'd4;
      drain(200);
      check_eq("wrap_rd_ptr", o_rd_ptr, LL);
      check_eq("wrap_empty", 32'(o_empty), 32'd1);
      check_state("wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ble_ring_reader.md
Name: ble_ring_reader

Overview:
- Drain side of the BLE receive ring buffer in RAM.
- The receive path writes one byte per 32-bit word at incrementing addresses in [ADR_LL..ADR_UL]. This block reads those words back in order as a Wishbone read master, chasing the writer's pointer.
- It hands each low byte to a uart_tx instance with a start/done handshake, so BLE traffic can be forwarded to the PC link without CPU involvement.
- The top level muxes its bus request onto the RAM only while the CPU is not cycling.

Parameters:
- ADR_LL, 'h730: first ring address, word-aligned.
- ADR_UL, 'h1FFC: last valid ring address, word-aligned.
- AW, 32: address width.

Ports:
- i_wb_clk  in  1  clock
- i_wb_rst  in  1  synchronous active-high reset
- i_en  in  1  enable streaming
- i_wr_ptr  in  AW  writer's next-write address
- i_wb_gnt  in  1  bus grant; high when the CPU has cyc low
- o_wb_adr  out  AW  read address
- o_wb_cyc  out  1  read request; we is implied 0 and sel is implied 4'b1111
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  read acknowledge
- o_tx_dat  out  8  byte to transmitter
- o_tx_active  out  1  one-cycle start pulse to uart_tx
- i_tx_done  in  1  one-cycle pulse from uart_tx at end of stop bit
- o_rd_ptr  out  AW  current read address
- o_empty  out  1  high when rd_ptr == normalized wr_ptr
- o_sent  out  16  count of bytes sent, wraps mod 2^16

Behaviour:
- Reset values (i_wb_rst is synchronous, applied on the clock edge, overrides everything):
  - o_rd_ptr = ADR_LL
  - o_wb_cyc = 0
  - o_wb_adr = ADR_LL
  - o_tx_active = 0
  - o_tx_dat = 0
  - o_sent = 0
  - state = IDLE
- Reset in any state aborts the operation. No tx pulse is issued after reset. A pending i_tx_done is ignored.
- Writer pointer normalization:
  - wn = ADR_LL if i_wr_ptr > ADR_UL or i_wr_ptr < ADR_LL, else i_wr_ptr.
  - This covers the writer's transient UL+4 value before its wrap.
- o_empty = (o_rd_ptr == wn), combinational.
- Pointer advance: next = (o_rd_ptr + 4 > ADR_UL) ? ADR_LL : o_rd_ptr + 4. The full AW-bit add must not be truncated.
- Overrun: not detected. If the writer laps the reader, the data is lost and the reader continues from its pointer.
- FSM states:
  - IDLE: when i_en & !o_empty & i_wb_gnt, go to REQ and, on that edge, set o_wb_cyc=1 and o_wb_adr=o_rd_ptr.
  - REQ: hold o_wb_cyc=1 and a stable o_wb_adr.
    - i_wb_ack: latch i_wb_rdt[7:0] into o_tx_dat, drop cyc, go to SEND.
    - i_wb_gnt low before ack: drop cyc, return to IDLE, pointer unchanged (retry later).
    - Ack and grant-loss in the same cycle: ack wins.
  - SEND: o_tx_active=1 for exactly this one cycle, then go to WAIT.
  - WAIT: on i_tx_done, go to ADV. A done pulse that arrives while not in WAIT is ignored.
  - ADV: o_rd_ptr <= next, o_sent <= o_sent+1, go to IDLE.
- Latency with servant_ram (ack one cycle after cyc):
  - cyc rises 1 cycle after IDLE's condition holds.
  - o_tx_active pulses 2 cycles after cyc rises.
  - Next request no earlier than 2 cycles after i_tx_done.
- i_en low mid-transfer: the current byte completes (through ADV). Then the block stays in IDLE.
- o_wb_cyc never asserts while i_wb_gnt is low in the same cycle it rises. It may remain high at most one cycle after grant drops.
- i_wr_ptr may change at any time. It is only sampled in IDLE for the empty check.

Test Plan:
- Reset then writer at ADR_LL -> o_empty=1, no cyc for 100 cycles, o_rd_ptr='h730.
- i_wr_ptr='h738, RAM['h730]=0x41, ['h734]=0x42, i_en=1, gnt=1 ->
  - two reads at 'h730 then 'h734;
  - o_tx_dat 0x41 then 0x42, each a single-cycle o_tx_active;
  - o_sent=2, o_rd_ptr='h738, o_empty=1.
- Wrap: preload rd_ptr='h1FFC, i_wr_ptr='h2000 -> treated as 'h730; one byte sent, o_rd_ptr='h730, o_empty=1.
- Grant loss: drop i_wb_gnt in the REQ cycle before ack -> cyc drops, no tx pulse, pointer unchanged. Restoring gnt gives a retry at the same address and the byte is sent once.
- i_en low during WAIT with 3 bytes pending -> exactly one byte completes, o_sent=1, then no further cyc.
- Reset asserted during WAIT -> all outputs at reset values the next cycle; a later i_tx_done produces no advance.
